divide32_request_sequencer: RTL

Upstream issue stage and downstream result capture for divide32_unsigned_restoring_remainder. Accepts divide requests from a valid/ready producer and drives the divider's dividend/divisor/start pins. Waits for the divider to report done, then captures quotient/remainder and returns them on a valid/ready response channel. Adds request tagging, divide-by-zero detection and a hang watchdog.

---
 rtl/divide32_request_sequencer_pkg.sv | 31 +++
 rtl/divide32_request_sequencer_if.sv | 60 ++++++
 rtl/divide32_request_sequencer_watchdog.sv | 57 +++++
 rtl/divide32_request_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/divide32_request_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : divide32_pkg
//  Description : Shared types and constants for the divide32 request
//                sequencer: sequencer state encoding, operand widths, the
//                quotient returned for a bypassed divide-by-zero, and a
//                helper that sizes the watchdog counter.
//  Revision    : 1.0  initial release
// ============================================================================
package divide32_pkg;

    localparam int DIVIDEND_W = 32;
    localparam int DIVISOR_W  = 16;

    localparam logic [DIVIDEND_W-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } state_e;

    // Counter must be able to hold the value WAIT_LIMIT itself.
    function automatic int wd_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage : divide32_pkg
`default_nettype wire

// File: rtl/divide32_request_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : divide32_request_sequencer_if
//  Description : Bundle of the request, response and divider-side signals of
//                the divide32 request sequencer.
//                  req_*  : valid/ready request channel (producer -> seq)
//                  rsp_*  : valid/ready response channel (seq -> consumer)
//                  div_*  : pins to/from the restoring divider
//                Modports: slave  = sequencer view
//                          master = environment (producer/consumer/divider)
//  Revision    : 1.0  initial release
// ============================================================================
interface divide32_request_sequencer_if
    import divide32_pkg::*;
#(
    parameter int TAG_W = 4
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic [DIVIDEND_W-1:0] req_dividend;
    logic [DIVISOR_W-1:0]  req_divisor;
    logic [TAG_W-1:0]      req_tag;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DIVIDEND_W-1:0] rsp_quotient;
    logic [DIVISOR_W-1:0]  rsp_remainder;
    logic [TAG_W-1:0]      rsp_tag;
    logic                  rsp_div0;
    logic                  rsp_timeout;

    logic [DIVIDEND_W-1:0] div_dividend;
    logic [DIVISOR_W-1:0]  div_divisor;
    logic                  div_start;
    logic [DIVIDEND_W-1:0] div_quotient;
    logic [DIVISOR_W-1:0]  div_remainder;
    logic                  div_ready;
    logic                  div_busy;

    modport slave (
        input  req_valid, req_dividend, req_divisor, req_tag,
        output req_ready,
        output rsp_valid, rsp_quotient, rsp_remainder, rsp_tag, rsp_div0, rsp_timeout,
        input  rsp_ready,
        output div_dividend, div_divisor, div_start,
        input  div_quotient, div_remainder, div_ready, div_busy
    );

    modport master (
        output req_valid, req_dividend, req_divisor, req_tag,
        input  req_ready,
        input  rsp_valid, rsp_quotient, rsp_remainder, rsp_tag, rsp_div0, rsp_timeout,
        output rsp_ready,
        input  div_dividend, div_divisor, div_start,
        output div_quotient, div_remainder, div_ready, div_busy
    );

endinterface : divide32_request_sequencer_if
`default_nettype wire

// File: rtl/divide32_request_sequencer_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : divseq_watchdog
//  Description : Loadable up-counter with clear and limit-hit flag used to
//                bound how long the sequencer waits on the divider.
//  Ports       : clock, reset   - clock, async active-high reset
//                clear_i        - force count to 0 (highest priority)
//                load_i         - load load_val_i
//                load_val_i     - value to load
//                inc_i          - count up by one
//                hit_o          - count is one short of WAIT_LIMIT, i.e. the
//                                 next increment reaches the limit
//  Revision    : 1.0  initial release
// ============================================================================
module divseq_watchdog
    import divide32_pkg::*;
#(
    parameter int WAIT_LIMIT = 48,
    localparam int CW        = wd_width(WAIT_LIMIT)
) (
    input  wire logic          clock,
    input  wire logic          reset,
    input  wire logic          clear_i,
    input  wire logic          load_i,
    input  wire logic [CW-1:0] load_val_i,
    input  wire logic          inc_i,
    output logic               hit_o
);

    localparam logic [CW-1:0] LAST_BEFORE_LIMIT = CW'(WAIT_LIMIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit_o = (count_q == LAST_BEFORE_LIMIT);

endmodule : divseq_watchdog
`default_nettype wire

// File: rtl/divide32_request_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : divide32_request_sequencer
//  Description : Issue/capture sequencer around a 32/16 restoring divider.
//                Accepts one request at a time, pulses div_start, waits for
//                the divider to go busy and then finish, and returns the
//                quotient/remainder with the request tag. Flags zero
//                divisors and gives up after WAIT_LIMIT cycles.
//  Ports       : clock, reset - clock, asynchronous active-high reset
//                bus          - divide32_request_sequencer_if.slave
//                               (req_*, rsp_*, div_* signal groups)
//  Options     : DIVSEQ_DIV0_BYPASS_EN - when defined, a zero divisor is
//                answered directly (quotient all ones, remainder = low half
//                of the dividend) without starting the divider.
//  Revision    : 1.0  initial release
// ============================================================================
module divide32_request_sequencer
    import divide32_pkg::*;
#(
    parameter int TAG_W      = 4,
    parameter int WAIT_LIMIT = 48   // must cover divider latency (>= 40)
) (
    input  wire logic                        clock,
    input  wire logic                        reset,
    divide32_request_sequencer_if.slave      bus
);

    localparam int CW = wd_width(WAIT_LIMIT);

    state_e                state_q,        state_d;
    logic [DIVIDEND_W-1:0] dividend_q,     dividend_d;
    logic [DIVISOR_W-1:0]  divisor_q,      divisor_d;
    logic [TAG_W-1:0]      tag_q,          tag_d;
    logic [DIVIDEND_W-1:0] rsp_quot_q,     rsp_quot_d;
    logic [DIVISOR_W-1:0]  rsp_rem_q,      rsp_rem_d;
    logic                  rsp_div0_q,     rsp_div0_d;
    logic                  rsp_timeout_q,  rsp_timeout_d;

    logic wd_clear;
    logic wd_load;
    logic wd_inc;
    logic wd_hit;

    // The watchdog measures cycles elapsed since ISSUE: loading 1 in ISSUE
    // makes the counter reach WAIT_LIMIT on the edge that leaves the wait
    // states exactly WAIT_LIMIT cycles after the start pulse.
    divseq_watchdog #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_watchdog (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (wd_clear),
        .load_i     (wd_load),
        .load_val_i (CW'(1)),
        .inc_i      (wd_inc),
        .hit_o      (wd_hit)
    );

    always_comb begin
        state_d       = state_q;
        dividend_d    = dividend_q;
        divisor_d     = divisor_q;
        tag_d         = tag_q;
        rsp_quot_d    = rsp_quot_q;
        rsp_rem_d     = rsp_rem_q;
        rsp_div0_d    = rsp_div0_q;
        rsp_timeout_d = rsp_timeout_q;
        wd_clear      = 1'b0;
        wd_load       = 1'b0;
        wd_inc        = 1'b0;

        case (state_q)
            IDLE: begin
                wd_clear = 1'b1;
                if (bus.req_valid) begin
                    dividend_d = bus.req_dividend;
                    divisor_d  = bus.req_divisor;
                    tag_d      = TAG_W'(bus.req_tag);
`ifdef DIVSEQ_DIV0_BYPASS_EN
                    if (bus.req_divisor == '0) begin
                        rsp_quot_d    = DIV0_QUOTIENT;
                        rsp_rem_d     = bus.req_dividend[DIVISOR_W-1:0];
                        rsp_div0_d    = 1'b1;
                        rsp_timeout_d = 1'b0;
                        state_d       = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
`else
                    state_d = ISSUE;
`endif
                end
            end

            ISSUE: begin
                wd_load = 1'b1;
                state_d = WAIT_BUSY;
            end

            WAIT_BUSY: begin
                wd_inc = 1'b1;
                if (wd_hit) begin
                    rsp_quot_d    = '0;
                    rsp_rem_d     = '0;
                    rsp_div0_d    = (divisor_q == '0);
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end else if (bus.div_busy) begin
                    state_d = WAIT_DONE;
                end
            end

            WAIT_DONE: begin
                wd_inc = 1'b1;
                // Completion is tested first so a result arriving on the
                // limit cycle is still delivered.
                if (!bus.div_busy && bus.div_ready) begin
                    rsp_quot_d    = bus.div_quotient;
                    rsp_rem_d     = bus.div_remainder;
                    rsp_div0_d    = (divisor_q == '0);
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (wd_hit) begin
                    rsp_quot_d    = '0;
                    rsp_rem_d     = '0;
                    rsp_div0_d    = (divisor_q == '0);
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end
            end

            RESP: begin
                // Returning through IDLE keeps req_ready low on the
                // handshake cycle, so there is no rsp_ready->req_ready path.
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            dividend_q    <= '0;
            divisor_q     <= '0;
            tag_q         <= '0;
            rsp_quot_q    <= '0;
            rsp_rem_q     <= '0;
            rsp_div0_q    <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dividend_q    <= dividend_d;
            divisor_q     <= divisor_d;
            tag_q         <= tag_d;
            rsp_quot_q    <= rsp_quot_d;
            rsp_rem_q     <= rsp_rem_d;
            rsp_div0_q    <= rsp_div0_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.req_ready     = (state_q == IDLE);
    assign bus.div_start     = (state_q == ISSUE);
    assign bus.rsp_valid     = (state_q == RESP);
    assign bus.div_dividend  = dividend_q;
    assign bus.div_divisor   = divisor_q;
    assign bus.rsp_quotient  = rsp_quot_q;
    assign bus.rsp_remainder = rsp_rem_q;
    assign bus.rsp_tag       = tag_q;
    assign bus.rsp_div0      = rsp_div0_q;
    assign bus.rsp_timeout   = rsp_timeout_q;

endmodule : divide32_request_sequencer
`default_nettype wire
